// File: rtl/inst_fetch_unit.sv
// Instruction fetch initiator: owns the PC, reads one word per cycle from a combinational ROM,
// and queues {pc, inst, adel} entries for decode behind a valid/ready handshake.
module inst_fetch_unit #(
    parameter int unsigned                  ADDR_WIDTH = 32,
    parameter int unsigned                  INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]        RESET_PC   = 32'hBFC00000,
    parameter int unsigned                  DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [INST_WIDTH-1:0] rom_inst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_adel
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [CNT_W-1:0]      count_q;
    logic [PTR_W-1:0]      wptr_q;
    logic [PTR_W-1:0]      rptr_q;
    logic                  halt_q;

    logic [ADDR_WIDTH-1:0] fifo_pc   [DEPTH];
    logic [INST_WIDTH-1:0] fifo_inst [DEPTH];
    logic                  fifo_adel [DEPTH];

    logic full;
    logic aligned;
    logic fetch_ok;
    logic push;
    logic pop;

    // rst gates the strobes so nothing is fetched or presented while reset is held
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        aligned   = (pc_q[1:0] == 2'b00);
        fetch_ok  = rst && !redirect_valid && !full && !halt_q;
        push      = fetch_ok;
        rom_en    = fetch_ok && aligned;
        rom_addr  = pc_q;
        out_valid = rst && (count_q != '0) && !redirect_valid;
        pop       = out_valid && out_ready;
        out_inst  = '0;
        out_pc    = '0;
        out_adel  = 1'b0;
        if (out_valid) begin
            out_inst = fifo_inst[rptr_q];
            out_pc   = fifo_pc[rptr_q];
            out_adel = fifo_adel[rptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            halt_q  <= 1'b0;
        end else if (redirect_valid) begin
            pc_q    <= redirect_pc;
            count_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            halt_q  <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
                // a misaligned PC is queued once as an address error, then fetch stalls
                if (aligned) begin
                    pc_q <= pc_q + ADDR_WIDTH'(4);
                end else begin
                    halt_q <= 1'b1;
                end
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wptr_q]   <= pc_q;
            fifo_inst[wptr_q] <= aligned ? rom_inst : '0;
            fifo_adel[wptr_q] <= !aligned;
        end
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction-fetch initiator that drives the combinational instruction ROM port (en, addr → 32-bit big-endian inst, same-cycle data). It holds the PC, issues one fetch per cycle, and buffers fetched words with their PC in a small FIFO. The FIFO feeds decode over a valid/ready handshake. It takes redirects (branch/exception) from the pipeline and flags misaligned fetch addresses.

Parameters:
ADDR_WIDTH, 32, width of PC / ROM address
INST_WIDTH, 32, width of instruction word
RESET_PC, 32'hBFC00000, PC loaded on reset
DEPTH, 2, FIFO entries (power of 2, ≥2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
rom_en  output  1  ROM read enable
rom_addr  output  ADDR_WIDTH  ROM byte address
rom_inst  input  INST_WIDTH  ROM read data, valid same cycle as rom_en
redirect_valid  input  1  pipeline redirect strobe
redirect_pc  input  ADDR_WIDTH  redirect target
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode accepts head entry
out_inst  output  INST_WIDTH  head instruction
out_pc  output  ADDR_WIDTH  head PC
out_adel  output  1  head entry is an address-error (misaligned fetch)

Behaviour:
- State: pc_q, fifo (pc, inst, adel per entry), count (0..DEPTH), halt_q (set after an address-error push).
- Reset (rst=0, async): pc_q=RESET_PC, count=0, pointers=0, halt_q=0. Outputs while reset is asserted: rom_en=0, rom_addr=RESET_PC, out_valid=0, out_inst=0, out_pc=0, out_adel=0.
- rom_addr=pc_q at all times.
- full = (count==DEPTH), from registered count. There is no same-cycle pop bypass.
- fetch_ok = !redirect_valid && !full && !halt_q.
- rom_en = fetch_ok && pc_q[1:0]==0.
- Aligned fetch (rom_en=1): push {pc_q, rom_inst, 0}; pc_q <= pc_q+4, modulo 2^ADDR_WIDTH (0xFFFFFFFC wraps to 0).
- Misaligned (fetch_ok && pc_q[1:0]!=0): rom_en=0; push {pc_q, 0, 1}; pc_q holds; halt_q<=1. No further fetches until a redirect.
- Pop: out_valid && out_ready. Simultaneous push and pop leaves count unchanged. Entries leave in fetch order.
- out_valid = (count!=0) && !redirect_valid.
- out_inst/out_pc/out_adel show the head entry when out_valid=1, else 0.
- Latency: a word fetched in cycle N is presented at the output in cycle N+1. Sustained throughput is 1 instr/cycle with out_ready=1.
- Redirect (highest priority): in the redirect cycle, rom_en=0, no push, pop ignored, out_valid=0. On the edge, count<=0, pointers reset, pc_q<=redirect_pc, halt_q<=0.
- Redirect while empty, full, or halted: same behaviour in every case.
- out_ready while empty is ignored.
- Reset mid-stream: all FIFO contents are discarded immediately (asynchronously). The first fetch after reset release is at RESET_PC on the first rising edge with rst=1.

Test Plan:
- RESET_PC=0; ROM bytes 0..7 = 3C 01 12 34 24 21 56 78; out_ready=1; release reset. Required: rom_addr 0 then 4 on successive cycles; out_inst 0x3C011234/pc 0, then 0x24215678/pc 4, one cycle after each fetch; out_adel=0.
- Backpressure with out_ready=0. Required: after 2 fetches, rom_en=0, pc_q/rom_addr held at 8, head stays pc 0. On raising out_ready: outputs pc 0, 4, 8 in order, no loss or duplication.
- With FIFO full, pulse redirect_valid with redirect_pc=0x100 for one cycle. Required: out_valid=0 and rom_en=0 that cycle; next cycle rom_addr=0x100; the cycle after, out_pc=0x100 and no old entries appear.
- Redirect to 0x102. Required: one entry with out_adel=1, out_inst=0, out_pc=0x102; rom_en stays 0 and no further entries appear. A redirect to 0x104 resumes fetching with out_pc=0x104.
- Redirect to 0xFFFFFFFC. Required: fetch addresses 0xFFFFFFFC then 0x00000000.
- Drive rst low between clock edges mid-stream. Required: out_valid=0, rom_en=0, rom_addr=RESET_PC immediately, before the next edge; after release the first entry has out_pc=RESET_PC.
